nr_div_param: RTL and testbench
===============================

// Module: nr_div_param
// PURPOSE
// Parametrised sequential non-restoring divider for the multdiv unit. Divides a WIDTH-bit dividend
// by a WIDTH-bit divisor in signed or unsigned mode and returns both quotient and remainder.
// Flags divide-by-zero and signed overflow through an early-exit path.
// Uses a start/busy/ready handshake toward the pipeline's multdiv stall logic.
// PARAMETERS
// WIDTH   32  operand, quotient and remainder width; legal range 4..64
// PORTS
// clock             in   1      rising-edge clock
// reset             in   1      synchronous, active-high; clears all state
// ctrl_DIV          in   1      start request, sampled each cycle
// ctrl_signed       in   1      1 = two's-complement operands, 0 = unsigned; latched at start
// data_operandA     in   WIDTH  dividend; latched at start
// data_operandB     in   WIDTH  divisor; latched at start
// data_quotient     out  WIDTH  quotient, held until the next accepted start
// data_remainder    out  WIDTH  remainder, held until the next accepted start
// data_exception    out  1      divide-by-zero or signed overflow; valid with the result
// data_resultRDY    out  1      one-cycle pulse when the result is valid
// busy              out  1      high in RUN and FIX
// BEHAVIOUR
// - One clock. Reset is synchronous and active-high. Reset sets state IDLE, all outputs 0 and the counter 0.
//   Reset overrides every other input, including a reset asserted mid-operation; no rdy pulse follows it.
// - FSM states:
//   - IDLE: waits for a start.
//   - RUN: iterates WIDTH times.
//   - FIX: corrects the remainder and applies signs.
//   - DONE: pulses data_resultRDY for one cycle, then goes to IDLE.
// - Start is accepted when ctrl_DIV=1 and the state is IDLE or DONE.
//   ctrl_DIV in RUN or FIX is ignored: no restart and no state corruption.
// - On accept at cycle T, latch mode, |A| and |B| (magnitudes only when ctrl_signed=1), plus the result signs.
//   Then set A_acc=0 and count=WIDTH, and go to RUN.
// - RUN step:
//   - if A_acc>=0: {A,Q} <<= 1, then A -= M; otherwise {A,Q} <<= 1, then A += M.
//   - Q[0] = ~A_new[MSB]; count decrements.
//   - A_acc is WIDTH+1 bits so that unsigned operands near 2^WIDTH cannot overflow.
//   - Leave RUN when count reaches 0.
// - FIX: if A_acc<0, add M once. The remainder is A_acc[WIDTH-1:0].
// - Sign application in FIX:
//   - Quotient is negated when the dividend sign XOR divisor sign is 1.
//   - Remainder takes the dividend's sign, so division truncates toward zero.
// - Normal latency: accepted at T, data_resultRDY high at T+WIDTH+2 (DONE), outputs updated on the same edge.
// - Early exit, no RUN: next state is DONE, so rdy is at T+1 with data_exception=1. Two cases:
//   - Divisor 0 (either mode): quotient = all ones, remainder = dividend.
//   - Signed mode with dividend = MIN and divisor = -1: quotient = MIN, remainder = 0.
// - data_exception is 0 for any normal completion. It is updated only on the DONE transition and held afterwards.
// - Start in DONE is accepted: the rdy pulse still fires in that cycle, and the new operation begins.
// - Operand inputs may change freely after accept; only the latched copies are used.
// STRUCTURE
// - Shared package div_pkg:
//   - state encoding localparams DIV_IDLE, DIV_RUN, DIV_FIX, DIV_DONE (2 bits)
//   - counter width function CNT_W = $clog2(WIDTH+1)
// - Sub-module nr_div_step: combinational. Takes A_acc, Q, M and returns the next A_acc and Q.
//   It contains the add/sub select, the shift and the quotient-bit rule.
// - Top level: FSM, counter, operand/sign latches, FIX correction and negation muxes, early-exit detect.
//   Registers use the codebase register primitives with enable, with the synchronous reset folded into d.
// TESTING (WIDTH=32 unless noted; T = accept cycle)
// - Signed 7 / 2 -> q=3, r=1, exc=0, rdy at T+34 only; busy high T+1..T+33.
// - Signed -7 / 2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7 / -2 -> q=-3, r=1.
// - Unsigned 0xFFFFFFFF / 1 -> q=0xFFFFFFFF, r=0. Unsigned 0x80000000 / 0xFFFFFFFF -> q=0, r=0x80000000.
// - Divide by zero -> rdy at T+1, exc=1, q=0xFFFFFFFF, r=dividend. Signed 0x80000000 / -1 -> rdy T+1, exc=1, q=0x80000000, r=0.
// - ctrl_DIV held high for 50 cycles -> exactly one accept per DONE, no mid-RUN restart.
//   Reset at T+10 -> IDLE with outputs 0 and no rdy pulse.
// - WIDTH=8, unsigned 200 / 7 -> q=28, r=4, rdy at T+10. Also a random signed/unsigned sweep against a reference model.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the non-restoring divider: FSM encoding and counter sizing.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  // The counter must be able to hold WIDTH itself, not just WIDTH-1.
  function automatic int CNT_W(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/nr_div_step.sv
// One non-restoring iteration: shift {A,Q} left, add or subtract M by the sign of A,
// and shift the new quotient bit in.
module nr_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] m_ext;

  assign shifted = {acc_i[WIDTH-1:0], q_i[WIDTH-1]};
  assign m_ext   = {1'b0, m_i};
  assign acc_o   = acc_i[WIDTH] ? (shifted + m_ext) : (shifted - m_ext);
  assign q_o     = {q_i[WIDTH-2:0], ~acc_o[WIDTH]};

endmodule

// File: rtl/nr_div_param.sv
// Sequential signed/unsigned non-restoring divider with start/busy/ready handshake
// and an early-exit path for divide-by-zero and signed overflow.
module nr_div_param
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic             ctrl_signed,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_quotient,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = CNT_W(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

  div_state_e       state_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] m_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_quot_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             exc_q;
  logic             rdy_q;

  logic [WIDTH:0]   acc_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] rem_mag_d;
  logic             a_neg, b_neg, div_zero, sgn_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;

  nr_div_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .q_i   (q_q),
    .m_i   (m_q),
    .acc_o (acc_d),
    .q_o   (q_d)
  );

  assign a_neg    = ctrl_signed & data_operandA[WIDTH-1];
  assign b_neg    = ctrl_signed & data_operandB[WIDTH-1];
  assign a_mag    = a_neg ? (~data_operandA + 1'b1) : data_operandA;
  assign b_mag    = b_neg ? (~data_operandB + 1'b1) : data_operandB;
  assign div_zero = (data_operandB == '0);
  assign sgn_ovf  = ctrl_signed && (data_operandA == MIN_VAL) && (data_operandB == ALL_ONE);

  // Low WIDTH bits only: the correction never needs the extension bit of the sum.
  assign rem_mag_d = acc_q[WIDTH-1:0] + (acc_q[WIDTH] ? m_q : '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= DIV_IDLE;
      acc_q      <= '0;
      q_q        <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      exc_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        DIV_IDLE, DIV_DONE: begin
          state_q <= DIV_IDLE;
          if (ctrl_DIV) begin
            if (div_zero) begin
              quot_q  <= ALL_ONE;
              rem_q   <= data_operandA;
              exc_q   <= 1'b1;
              rdy_q   <= 1'b1;
              state_q <= DIV_DONE;
            end else if (sgn_ovf) begin
              quot_q  <= MIN_VAL;
              rem_q   <= '0;
              exc_q   <= 1'b1;
              rdy_q   <= 1'b1;
              state_q <= DIV_DONE;
            end else begin
              acc_q      <= '0;
              q_q        <= a_mag;
              m_q        <= b_mag;
              neg_quot_q <= a_neg ^ b_neg;
              neg_rem_q  <= a_neg;
              cnt_q      <= CW'(WIDTH);
              state_q    <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= DIV_FIX;
        end
        DIV_FIX: begin
          quot_q  <= neg_quot_q ? (~q_q + 1'b1) : q_q;
          rem_q   <= neg_rem_q ? (~rem_mag_d + 1'b1) : rem_mag_d;
          exc_q   <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= DIV_DONE;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign data_quotient  = quot_q;
  assign data_remainder = rem_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q == DIV_RUN) || (state_q == DIV_FIX);

endmodule

// File: tb/tb_nr_div_param.sv
// Directed and small random checks of nr_div_param at WIDTH=32 and WIDTH=8.
module tb_nr_div_param;

  logic        clock = 1'b0;
  logic        reset;
  logic        div32, sgn32;
  logic [31:0] a32, b32, q32, r32;
  logic        exc32, rdy32, busy32;
  logic        div8, sgn8;
  logic [7:0]  a8, b8, q8, r8;
  logic        exc8, rdy8, busy8;

  int n_pass = 0;
  int n_checks = 0;

  always #5 clock = ~clock;

  nr_div_param #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .ctrl_DIV(div32), .ctrl_signed(sgn32),
    .data_operandA(a32), .data_operandB(b32), .data_quotient(q32),
    .data_remainder(r32), .data_exception(exc32), .data_resultRDY(rdy32), .busy(busy32)
  );

  nr_div_param #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .ctrl_DIV(div8), .ctrl_signed(sgn8),
    .data_operandA(a8), .data_operandB(b8), .data_quotient(q8),
    .data_remainder(r8), .data_exception(exc8), .data_resultRDY(rdy8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Start one 32-bit division in the current cycle (T) and check the result.
  task automatic run32(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic ee, input int elat);
    int k;
    logic busy_ok;
    div32 = 1'b1; sgn32 = s; a32 = a; b32 = b;
    @(negedge clock);
    div32 = 1'b0; a32 = 32'h5A5A_1234; b32 = 32'h0000_0000; sgn32 = ~s;
    k = 1;
    busy_ok = 1'b1;
    while (!rdy32 && k < 100) begin
      if (!busy32) busy_ok = 1'b0;
      @(negedge clock);
      k++;
    end
    $display("div32 %s s=%0d a=0x%h b=0x%h -> q=0x%h r=0x%h exc=%0d lat=%0d",
             tag, s, a, b, q32, r32, exc32, k);
    check({tag, ".lat"}, 64'(k), 64'(elat));
    check({tag, ".q"}, 64'(q32), 64'(eq));
    check({tag, ".r"}, 64'(r32), 64'(er));
    check({tag, ".exc"}, 64'(exc32), 64'(ee));
    check({tag, ".busy"}, 64'(busy_ok), 64'(1));
    @(negedge clock);
    check({tag, ".pulse"}, 64'(rdy32), 64'(0));
    check({tag, ".hold_q"}, 64'(q32), 64'(eq));
  endtask

  initial begin
    int k, rdy_cnt, first_rdy, second_rdy;
    logic [31:0] ra, rb, eq, er;
    logic rs;
    reset = 1'b1; div32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    div8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst.q", 64'(q32), 64'(0));
    check("rst.r", 64'(r32), 64'(0));
    check("rst.ctl", 64'({exc32, rdy32, busy32}), 64'(0));

    run32("s7d2",   1'b1, 32'd7,          32'd2,          32'd3,          32'd1,          1'b0, 34);
    run32("sm7d2",  1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34);
    run32("s7dm2",  1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 34);
    run32("uffd1",  1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 34);
    run32("u8dff",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 34);
    run32("u100d7", 1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34);
    run32("udz",    1'b0, 32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234,       1'b1, 1);
    run32("sdz",    1'b1, 32'hFFFF_FF00,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FF00,  1'b1, 1);
    run32("sovf",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b1, 1);
    run32("after",  1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 34);

    // ctrl_DIV held for 50 cycles: accepts at T and at the DONE cycle T+34 only.
    div32 = 1'b1; sgn32 = 1'b1; a32 = 32'd7; b32 = 32'd2;
    rdy_cnt = 0; first_rdy = 0; second_rdy = 0;
    for (int c = 1; c <= 76; c++) begin
      @(negedge clock);
      if (c == 50) div32 = 1'b0;
      if (rdy32) begin
        rdy_cnt++;
        if (rdy_cnt == 1) first_rdy = c;
        if (rdy_cnt == 2) second_rdy = c;
      end
    end
    $display("hold ctrl_DIV 50 cycles -> rdy pulses=%0d at %0d,%0d", rdy_cnt, first_rdy, second_rdy);
    check("hold.cnt", 64'(rdy_cnt), 64'(2));
    check("hold.first", 64'(first_rdy), 64'(34));
    check("hold.second", 64'(second_rdy), 64'(68));
    check("hold.q", 64'(q32), 64'(3));

    // Reset at T+10 aborts the run without a rdy pulse.
    div32 = 1'b1; sgn32 = 1'b0; a32 = 32'd50; b32 = 32'd3;
    @(negedge clock);
    div32 = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mrst.q", 64'(q32), 64'(0));
    check("mrst.ctl", 64'({exc32, rdy32, busy32}), 64'(0));
    rdy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (rdy32 || busy32) rdy_cnt++;
    end
    $display("mid-run reset -> stray rdy/busy cycles=%0d", rdy_cnt);
    check("mrst.quiet", 64'(rdy_cnt), 64'(0));

    // WIDTH=8 unsigned 200 / 7.
    div8 = 1'b1; sgn8 = 1'b0; a8 = 8'd200; b8 = 8'd7;
    @(negedge clock);
    div8 = 1'b0; a8 = 8'hFF; b8 = 8'h00;
    k = 1;
    while (!rdy8 && k < 100) begin
      @(negedge clock);
      k++;
    end
    $display("div8 u 200/7 -> q=%0d r=%0d exc=%0d lat=%0d", q8, r8, exc8, k);
    check("w8.lat", 64'(k), 64'(10));
    check("w8.q", 64'(q8), 64'(28));
    check("w8.r", 64'(r8), 64'(4));
    check("w8.exc", 64'(exc8), 64'(0));

    // Random sweep against the language's own truncating division.
    for (int i = 0; i < 16; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i < 8) ? $urandom : 32'($urandom_range(1, 1000));
      if (i % 4 == 3) rb = -rb;
      if (rb == 0) rb = 32'd5;
      if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      if (rs) begin
        eq = 32'($signed(ra) / $signed(rb));
        er = 32'($signed(ra) % $signed(rb));
      end else begin
        eq = ra / rb;
        er = ra % rb;
      end
      run32($sformatf("rnd%0d", i), rs, ra, rb, eq, er, 1'b0, 34);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
